dmem_bridge: RTL

//  Data-memory bridge downstream of the single-cycle datapath: consumes aluout (address),

---
 rtl/dmem_bridge.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/dmem_bridge.sv
// Data-memory bridge: turns datapath load/store strobes into a req/ack bus transaction and
// stalls the core until it retires. Define DMEM_ALIGN_CHECK_EN to reject misaligned accesses.
module dmem_bridge #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memread,
  input  logic          memwrite,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          stall,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic          bus_ack,
  input  logic [DW-1:0] bus_rdata,
  output logic          err,
  output logic          misalign
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] CntLast = CW'(TIMEOUT - 1);
  localparam logic [31:0] ReadErrWord = 32'hDEADBEEF;
  localparam logic [DW-1:0] ReadErr = DW'(ReadErrWord);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          access;
  logic          bad_align;

  assign access = memread | memwrite;

`ifdef DMEM_ALIGN_CHECK_EN
  logic mis_q, mis_d;
  assign bad_align = (addr[1:0] != 2'b00);
  assign misalign  = mis_q;
`else
  // Low address bits are dropped silently in this build.
  logic unused_addr_lo;
  assign unused_addr_lo = ^addr[1:0];
  assign bad_align      = 1'b0;
  assign misalign       = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef DMEM_ALIGN_CHECK_EN
    mis_d   = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (access) begin
          if (bad_align) begin
            err_d   = 1'b1;
            state_d = StDone;
`ifdef DMEM_ALIGN_CHECK_EN
            mis_d   = 1'b1;
`endif
          end else begin
            addr_d  = {addr[AW-1:2], 2'b00};
            wdata_d = wdata;
            we_d    = memwrite;
            req_d   = 1'b1;
            cnt_d   = '0;
            state_d = StReq;
          end
        end
      end
      StReq: begin
        if (bus_ack) begin
          req_d   = 1'b0;
          if (!we_q) rdata_d = bus_rdata;
          state_d = StDone;
        end else if (cnt_q == CntLast) begin
          // Abort: memory never answered within the wait budget.
          req_d   = 1'b0;
          err_d   = 1'b1;
          if (!we_q) rdata_d = ReadErr;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef DMEM_ALIGN_CHECK_EN
      mis_q   <= mis_d;
`endif
    end
  end

  // The retiring instruction sees stall low only in DONE.
  assign stall     = access & (state_q != StDone);
  assign bus_req   = req_q;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign rdata     = rdata_q;
  assign err       = err_q;

endmodule
